// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution sequencer and the 128x32
// convolution datapath it controls.
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    READ = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } conv_state_t;

  localparam int CONV_N      = 128;
  localparam int CONV_M      = 32;
  localparam int CONV_NY     = CONV_N - CONV_M + 1;
  localparam int CONV_LOGN   = 7;
  localparam int CONV_LOGM   = 5;
  localparam int CONV_DATA_W = 8;
  localparam int CONV_RES_W  = 21;

endpackage

// File: rtl/load_counter.sv
// Saturating handshake write-address counter for one load stream: accepts
// words while enabled and below LIMIT and exposes the next write address.
module load_counter #(
  parameter int ADDR_W = 7,
  parameter int LIMIT  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] addr,
  output logic              full
);

  localparam int CNT_W = ADDR_W + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full    = (cnt_q == CNT_W'(LIMIT));
  // Ready is gated by the raw reset so it drops the moment reset asserts.
  assign s_ready = reset & enable & ~full;
  assign wr_en   = s_valid & s_ready;
  assign addr    = cnt_q[ADDR_W-1:0];

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (wr_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Convolution sequencer: one FSM loads x/f over two valid/ready streams,
// walks the read window, pulses the MAC and streams results out.
// Build option: CONV_SEQ_FILTER_REUSE_EN keeps the filter across jobs.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int N    = CONV_N,
  parameter int M    = CONV_M,
  parameter int LOGN = CONV_LOGN,
  parameter int LOGM = CONV_LOGM
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid_x,
  output logic            s_ready_x,
  input  logic            s_valid_f,
  output logic            s_ready_f,
  output logic [LOGN-1:0] addr_x,
  output logic            wr_en_x,
  output logic [LOGM-1:0] addr_f,
  output logic            wr_en_f,
  output logic            en_acc,
  output logic            clr_acc,
  output logic            m_valid_y,
  input  logic            m_ready_y,
  output logic            job_done
);

  localparam logic [LOGN-1:0] K_LAST = LOGN'(N - M);

  conv_state_t     state_q, state_d;
  logic [LOGN-1:0] k_q, k_d;
  logic            job_done_q, job_done_d;

  logic            load_en;
  logic            job_end;
  logic            clear_x, clear_f;
  logic            full_x, full_f;
  logic [LOGN-1:0] wr_addr_x;
  logic [LOGM-1:0] wr_addr_f;

  assign load_en = (state_q == LOAD);
  assign job_end = (state_q == OUT) && m_ready_y && (k_q == K_LAST);
  assign clear_x = job_end;

`ifdef CONV_SEQ_FILTER_REUSE_EN
  logic f_loaded_q, f_loaded_d;

  // Once a full filter has been seen it is kept; only reset forgets it.
  always_comb begin
    f_loaded_d = f_loaded_q | full_f;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_loaded_q <= 1'b0;
    end else begin
      f_loaded_q <= f_loaded_d;
    end
  end

  assign clear_f = job_end & ~f_loaded_q;
`else
  assign clear_f = job_end;
`endif

  load_counter #(
    .ADDR_W (LOGN),
    .LIMIT  (N)
  ) u_load_x (
    .clk     (clk),
    .reset   (reset),
    .enable  (load_en),
    .clear   (clear_x),
    .s_valid (s_valid_x),
    .s_ready (s_ready_x),
    .wr_en   (wr_en_x),
    .addr    (wr_addr_x),
    .full    (full_x)
  );

  load_counter #(
    .ADDR_W (LOGM),
    .LIMIT  (M)
  ) u_load_f (
    .clk     (clk),
    .reset   (reset),
    .enable  (load_en),
    .clear   (clear_f),
    .s_valid (s_valid_f),
    .s_ready (s_ready_f),
    .wr_en   (wr_en_f),
    .addr    (wr_addr_f),
    .full    (full_f)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    job_done_d = 1'b0;
    addr_x     = k_q;
    addr_f     = '0;
    en_acc     = 1'b0;
    clr_acc    = 1'b0;
    m_valid_y  = 1'b0;

    case (state_q)
      LOAD: begin
        addr_x  = wr_addr_x;
        addr_f  = wr_addr_f;
        clr_acc = 1'b1;
        if (full_x && full_f) begin
          state_d = READ;
        end
      end
      READ: begin
        state_d = CALC;
      end
      CALC: begin
        en_acc  = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        m_valid_y = 1'b1;
        if (m_ready_y) begin
          if (k_q == K_LAST) begin
            k_d        = '0;
            job_done_d = 1'b1;
            state_d    = LOAD;
          end else begin
            k_d     = k_q + LOGN'(1);
            state_d = READ;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LOAD;
      k_q        <= '0;
      job_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      job_done_q <= job_done_d;
    end
  end

  assign job_done = job_done_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: models the x/f memories and MAC around the
// sequencer and checks results against a direct convolution of the loaded data.
module tb_conv_sequencer;
  import conv_pkg::*;

  localparam int N  = CONV_N;
  localparam int M  = CONV_M;
  localparam int NY = CONV_NY;

`ifdef CONV_SEQ_FILTER_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_valid_x = 1'b0;
  logic       s_ready_x;
  logic       s_valid_f = 1'b0;
  logic       s_ready_f;
  logic [6:0] addr_x;
  logic       wr_en_x;
  logic [4:0] addr_f;
  logic       wr_en_f;
  logic       en_acc;
  logic       clr_acc;
  logic       m_valid_y;
  logic       m_ready_y = 1'b0;
  logic       job_done;

  logic signed [7:0] s_data_x = '0;
  logic signed [7:0] s_data_f = '0;

  conv_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid_x (s_valid_x),
    .s_ready_x (s_ready_x),
    .s_valid_f (s_valid_f),
    .s_ready_f (s_ready_f),
    .addr_x    (addr_x),
    .wr_en_x   (wr_en_x),
    .addr_f    (addr_f),
    .wr_en_f   (wr_en_f),
    .en_acc    (en_acc),
    .clr_acc   (clr_acc),
    .m_valid_y (m_valid_y),
    .m_ready_y (m_ready_y),
    .job_done  (job_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath around the sequencer: memories, registered window, MAC register.
  logic signed [7:0]  xm [N];
  logic signed [7:0]  fm [M];
  logic signed [7:0]  xw [M];
  logic signed [7:0]  fw [M];
  logic signed [20:0] y = '0;

  function automatic logic signed [20:0] mac_now();
    int s = 0;
    for (int i = 0; i < M; i++) s += int'(xw[i]) * int'(fw[i]);
    return 21'(s);
  endfunction

  always @(posedge clk) begin
    if (wr_en_x) xm[addr_x] <= s_data_x;
    if (wr_en_f) fm[addr_f] <= s_data_f;
    for (int i = 0; i < M; i++) begin
      xw[i] <= xm[(int'(addr_x) + i) % N];
      fw[i] <= fm[(int'(addr_f) + i) % M];
    end
    if (clr_acc) y <= '0;
    else if (en_acc) y <= mac_now();
  end

  // Reference: data offered per job and the filter/input memory contents implied.
  int xd [N];
  int fd [M];
  int rx [N];
  int rf [M];
  int last_hs = 0;
  int total = 0;
  int bad = 0;

  function automatic int ref_y(input int k);
    int s = 0;
    for (int j = 0; j < M; j++) s += rx[k + j] * rf[j];
    return s;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic set_job(input int kind, input bit do_f);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       xd[i] = 1;
        1:       xd[i] = i - 64;
        default: xd[i] = int'($urandom_range(0, 255)) - 128;
      endcase
      rx[i] = xd[i];
    end
    for (int j = 0; j < M; j++) begin
      fd[j] = (kind < 2) ? 1 : int'($urandom_range(0, 255)) - 128;
      if (do_f) rf[j] = fd[j];
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk(nm, longint'({s_ready_x, s_ready_f, wr_en_x, wr_en_f, en_acc, clr_acc,
                      m_valid_y, job_done, addr_x, addr_f}),
        longint'({8'b0000_0100, 12'd0}));
  endtask

  task automatic load_job(input int ix0, input int jf0, input int x_pct, input bit do_f);
    int ix = ix0;
    int jf = jf0;
    int guard = 0;
    int bad_ld = 0;
    while ((ix < N || (do_f && jf < M)) && guard < 3000) begin
      @(negedge clk);
      s_valid_x = (ix < N) && (int'($urandom_range(0, 99)) < x_pct);
      s_data_x  = 8'(xd[(ix < N) ? ix : 0]);
      s_valid_f = do_f ? (jf < M) : 1'($urandom_range(0, 1));
      s_data_f  = (do_f && jf < M) ? 8'(fd[jf]) : 8'sh5A;
      m_ready_y = 1'($urandom_range(0, 1));
      #1;
      if (m_valid_y || en_acc || !clr_acc) bad_ld++;
      if ((ix < N) != s_ready_x) bad_ld++;
      if ((do_f && jf < M) != s_ready_f) bad_ld++;
      if (wr_en_x != (s_valid_x && s_ready_x)) bad_ld++;
      if (wr_en_f != (s_valid_f && s_ready_f)) bad_ld++;
      if (s_valid_x && s_ready_x) begin ix++; last_hs = cyc; end
      if (s_valid_f && s_ready_f) begin jf++; last_hs = cyc; end
      guard++;
    end
    chk("load_words_x", ix, N);
    chk("load_protocol", bad_ld, 0);
    @(negedge clk);
    s_valid_x = 1'b1;
    s_valid_f = 1'b1;
    #1;
    chk("ready_after_load", longint'({s_ready_x, s_ready_f, wr_en_x, wr_en_f}), 0);
  endtask

  task automatic collect(input int rdy_pct, input int bp_k, input int abort_k);
    int got = 0;
    int guard = 0;
    int nbad_wr = 0;
    int nbad_hold = 0;
    int gap_bad = 0;
    int early_done = 0;
    int bp_cnt = 0;
    int last_hs_y = -1;
    bit prev_v = 1'b0;
    bit aborted = 1'b0;
    logic signed [20:0] prev_y = '0;
    while (got < NY && guard < 4000 && !aborted) begin
      @(negedge clk);
      if (got == bp_k && bp_cnt < 10) m_ready_y = 1'b0;
      else m_ready_y = (int'($urandom_range(0, 99)) < rdy_pct);
      s_valid_x = 1'($urandom_range(0, 1));
      s_valid_f = 1'($urandom_range(0, 1));
      #1;
      if (s_ready_x || s_ready_f || wr_en_x || wr_en_f) nbad_wr++;
      if (job_done) early_done++;
      if (m_valid_y) begin
        if (addr_x != 7'(got) || en_acc || clr_acc) nbad_hold++;
        if (!prev_v) begin
          chk($sformatf("y%0d", got), longint'(y), longint'(ref_y(got)));
          if (last_hs_y < 0) chk("first_latency", cyc - last_hs, 4);
          else if (cyc - last_hs_y != 3) gap_bad++;
        end else if (y != prev_y) begin
          nbad_hold++;
        end
        if (got == bp_k && !m_ready_y) bp_cnt++;
        if (got == abort_k) begin
          #2 reset = 1'b0;
          #1 check_reset_outputs("abort_outputs");
          @(negedge clk);
          s_valid_x = 1'b0;
          s_valid_f = 1'b0;
          m_ready_y = 1'b0;
          reset = 1'b1;
          #1;
          chk("ready_after_abort", longint'({s_ready_x, s_ready_f}), 3);
          aborted = 1'b1;
        end else if (m_ready_y) begin
          got++;
          prev_v = 1'b0;
          last_hs_y = cyc;
        end else begin
          prev_v = 1'b1;
          prev_y = y;
        end
      end else if (prev_v) begin
        nbad_hold++;
        prev_v = 1'b0;
      end
      guard++;
    end
    if (!aborted) begin
      chk("results_count", got, NY);
      chk("no_load_outside", nbad_wr, 0);
      chk("hold_stable", nbad_hold, 0);
      chk("interval3", gap_bad, 0);
      chk("early_done", early_done, 0);
      if (bp_k >= 0) chk("bp_stall_cycles", bp_cnt, 10);
      @(negedge clk);
      s_valid_x = 1'b0;
      s_valid_f = 1'b0;
      m_ready_y = 1'b0;
      #1;
      chk("job_done_pulse", job_done, 1);
      chk("ready_next_job", longint'({s_ready_x, s_ready_f}), longint'({1'b1, !REUSE}));
      @(negedge clk);
      #1;
      chk("job_done_single", job_done, 0);
    end
  endtask

  typedef struct {
    bit vx, vf;
    bit rx, rf, wx, wf;
    int ax, af;
  } vec_t;

  vec_t tv [5];

  initial begin
    int ix;
    int jf;
    tv[0] = '{0, 0, 1, 1, 0, 0, 0, 0};
    tv[1] = '{1, 0, 1, 1, 1, 0, 0, 0};
    tv[2] = '{1, 1, 1, 1, 1, 1, 1, 0};
    tv[3] = '{0, 1, 1, 1, 0, 1, 2, 1};
    tv[4] = '{0, 0, 1, 1, 0, 0, 2, 2};

    s_valid_x = 1'b1;
    s_valid_f = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset_state");
    @(negedge clk);
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    reset = 1'b1;

    // Job A: all ones, first words handled from the vector table.
    set_job(0, 1'b1);
    ix = 0;
    jf = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid_x = tv[i].vx;
      s_valid_f = tv[i].vf;
      s_data_x  = 8'(xd[ix]);
      s_data_f  = 8'(fd[jf]);
      #1;
      chk($sformatf("tv%0d_ready", i), longint'({s_ready_x, s_ready_f}), longint'({tv[i].rx, tv[i].rf}));
      chk($sformatf("tv%0d_wren", i), longint'({wr_en_x, wr_en_f}), longint'({tv[i].wx, tv[i].wf}));
      chk($sformatf("tv%0d_addr_x", i), addr_x, tv[i].ax);
      chk($sformatf("tv%0d_addr_f", i), addr_f, tv[i].af);
      if (tv[i].vx) ix++;
      if (tv[i].vf) jf++;
    end
    load_job(ix, jf, 100, 1'b1);
    collect(100, -1, -1);

    // Job B: ramp input with backpressure at k=5.
    set_job(1, !REUSE);
    load_job(0, 0, 100, !REUSE);
    collect(100, 5, -1);

    // Job C: filter in a burst, x at 50% valid, random downstream ready.
    set_job(2, !REUSE);
    load_job(0, 0, 50, !REUSE);
    collect(50, -1, -1);

    // Job D: aborted by reset at k=40; job E reloads everything.
    set_job(2, !REUSE);
    load_job(0, 0, 80, !REUSE);
    collect(60, -1, 40);
    set_job(2, 1'b1);
    load_job(0, 0, 75, 1'b1);
    collect(70, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
